midi_tx: RTL
============

Name: midi_tx

Overview:
- MIDI transmitter: the outbound counterpart to the rx UART receiver and midi decoder path.
- Takes a note-on or note-off request and encodes it as a 3-byte MIDI channel message.
- Serialises the message as 8N1 UART at the MIDI baud rate on txData_o.
- Used for MIDI-thru/echo and as a stimulus source for loopback testing of the synth.

Parameters:
- CLK_FREQ, 10_000_000: system clock frequency in Hz.
- BAUD_RATE, 31250: MIDI baud rate.
- MIDI_CHANNEL, 0: 4-bit channel encoded into the status nibble (0..15).

Ports:
- clk_i  in  1  system clock.
- nrst_i  in  1  reset, asynchronous, active-low.
- noteOnStrb_i  in  1  one-cycle request to send Note On.
- noteOffStrb_i  in  1  one-cycle request to send Note Off.
- note_i  in  `MIDI_PAYLOAD_BITS  note number; bit 7 forced to 0 on transmit.
- velocity_i  in  `MIDI_PAYLOAD_BITS  velocity; bit 7 forced to 0 on transmit.
- txData_o  out  1  UART serial line, idle high.
- busy_o  out  1  high while a message is in flight.
- doneStrb_o  out  1  one-cycle pulse when a message completes.

Behaviour:
- Clocking: one clock (clk_i). Reset nrst_i is asynchronous, active-low.
- Reset values: txData_o=1, busy_o=0, doneStrb_o=0, FSM=IDLE, all counters 0.
- Bit timing: CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division (320 at defaults). Each bit is held for exactly CLKS_PER_BIT cycles.
- Frame: start bit 0, 8 data bits LSB first, stop bit 1 (10 bits).
- Message encoding:
  - Note On: {0x9, MIDI_CHANNEL}, {0, note_i[6:0]}, {0, velocity_i[6:0]}.
  - Note Off: {0x8, MIDI_CHANNEL}, same two data bytes.
  - No running status: every message carries its status byte.
- Acceptance: a strobe is accepted only in IDLE (busy_o=0). note_i and velocity_i are captured in the acceptance cycle N. Later input changes have no effect on the message.
- Latency: the start bit appears on txData_o at cycle N+1. busy_o rises at N+1.
- Frames are sent back to back with no idle gap. Total message time is 30*CLKS_PER_BIT cycles.
- Completion: in the cycle after the final stop bit ends, busy_o falls and doneStrb_o pulses for 1 cycle. A new strobe is accepted in that same cycle.
- Strobes arriving while busy_o=1 are dropped silently. There is no queue.
- Simultaneous noteOnStrb_i and noteOffStrb_i: Note On wins and Note Off is dropped.
- Reset mid-message: txData_o returns high asynchronously, the message is abandoned, and no doneStrb_o is generated.
- FSM states:
  - IDLE → STATUS on an accepted strobe.
  - STATUS → DATA1 when the byte-tx done pulse arrives.
  - DATA1 → DATA2 on byte-tx done.
  - DATA2 → IDLE on byte-tx done, asserting doneStrb_o.
- Byte sub-module handshake: start/byte/busy/done. start is only issued while the sub-module is idle. The next byte's start is issued in the same cycle as done, which guarantees zero gap.

Decomposition:
- Shared package/defines:
  - `MIDI_PAYLOAD_BITS (8).
  - MIDI_NOTE_ON (4'h9) and MIDI_NOTE_OFF (4'h8) status nibbles.
  - The CLKS_PER_BIT derivation, so rx and tx share bit timing.
- Sub-module tx: UART byte transmitter, the mirror of rx.
  - Baud counter, 4-bit bit index, 10-bit shift register.
  - Ports clk_i, nrst_i, start_i, data_i[7:0], txData_o, busy_o, done_o.
- midi_tx contains the message FSM, the byte mux and the captured registers.

Test Plan:
1. Defaults; noteOnStrb_i with note_i=0x3C, velocity_i=0x64 → line carries 0x90, 0x3C, 0x64 LSB first. Each bit is 320 cycles; busy_o high for 9600 cycles; one doneStrb_o pulse.
2. MIDI_CHANNEL=5; noteOffStrb_i with note_i=0xC5, velocity_i=0x80 → bytes 0x85, 0x45, 0x00 (MSBs masked).
3. Second noteOnStrb_i at cycle 1000 of a message → dropped; exactly 3 frames sent. A strobe in the doneStrb_o cycle → new start bit on the next cycle.
4. noteOnStrb_i and noteOffStrb_i in the same cycle with note_i=0x40 → status byte 0x90 only; a single message.
5. nrst_i low midway through DATA1 → txData_o=1 and busy_o=0 immediately; no doneStrb_o. After release, a new request transmits correctly.
6. Loopback txData_o→rx→midi (channel 0), note-on with note 0x3C → decoder noteOnStrb_o pulses with note_o=0x3C.

Source files
------------

// File: rtl/midi_tx_pkg.sv
// midi_tx_pkg: definitions shared by the MIDI rx and tx paths.
//   - payload width, Note On/Off status nibbles, UART frame length
//   - message FSM state type
//   - clksPerBit(): bit-period derivation, so rx and tx always agree on timing
`ifndef MIDI_PAYLOAD_BITS
`define MIDI_PAYLOAD_BITS 8
`endif

package midi_tx_pkg;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam int         FRAME_BITS    = 10;   // start + 8 data + stop

  typedef enum logic [1:0] {
    IDLE,
    STATUS,
    DATA1,
    DATA2
  } msgState_e;

  // Truncating division: any remainder is dropped, matching the rx sampler.
  function automatic int clksPerBit(input int clkFreq, input int baudRate);
    return clkFreq / baudRate;
  endfunction
endpackage

// File: rtl/midi_tx_byte.sv
// midi_tx_byte: 8N1 UART byte transmitter (mirror of the rx receiver).
// Ports:
//   clk_i, nrst_i  clock, async active-low reset
//   start_i        load data_i and begin a frame; taken when idle or in the done cycle
//   data_i[7:0]    byte to send, LSB first
//   txData_o       serial line, idle high
//   busy_o         frame in flight
//   done_o         high during the last cycle of the stop bit
module midi_tx_byte
  import midi_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 320
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       txData_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0]      baudCnt;
  logic [3:0]            bitIdx;
  logic [FRAME_BITS-1:0] shiftReg;
  logic                  bitEnd;

  assign bitEnd   = (baudCnt == CNT_W'(CLKS_PER_BIT - 1));
  // done is combinational so the next frame can be loaded in the same cycle,
  // giving back-to-back frames with no idle gap.
  assign done_o   = busy_o && bitEnd && (bitIdx == 4'(FRAME_BITS - 1));
  // Line is the shift register LSB: registered, and ones-filled when idle/reset.
  assign txData_o = shiftReg[0];

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      shiftReg <= '1;
      busy_o   <= 1'b0;
      baudCnt  <= '0;
      bitIdx   <= '0;
    end else if (start_i && (!busy_o || done_o)) begin
      shiftReg <= {1'b1, data_i, 1'b0};
      busy_o   <= 1'b1;
      baudCnt  <= '0;
      bitIdx   <= '0;
    end else if (busy_o) begin
      if (bitEnd) begin
        baudCnt  <= '0;
        shiftReg <= {1'b1, shiftReg[FRAME_BITS-1:1]};
        if (bitIdx == 4'(FRAME_BITS - 1)) begin
          busy_o <= 1'b0;
          bitIdx <= '0;
        end else begin
          bitIdx <= bitIdx + 4'd1;
        end
      end else begin
        baudCnt <= baudCnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/midi_tx.sv
// midi_tx: encodes a Note On / Note Off request as a 3-byte MIDI channel
// message and sends it as back-to-back 8N1 frames.
// Ports:
//   clk_i, nrst_i     clock, async active-low reset
//   noteOnStrb_i      one-cycle Note On request (wins over Note Off)
//   noteOffStrb_i     one-cycle Note Off request
//   note_i, velocity_i payload bytes, bit 7 cleared on transmit
//   txData_o          UART line, idle high
//   busy_o            message in flight; requests are dropped while high
//   doneStrb_o        one-cycle pulse after the last stop bit
module midi_tx
  import midi_tx_pkg::*;
#(
  parameter int CLK_FREQ     = 10_000_000,
  parameter int BAUD_RATE    = 31250,
  parameter int MIDI_CHANNEL = 0
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic                          noteOnStrb_i,
  input  logic                          noteOffStrb_i,
  input  logic [`MIDI_PAYLOAD_BITS-1:0] note_i,
  input  logic [`MIDI_PAYLOAD_BITS-1:0] velocity_i,
  output logic                          txData_o,
  output logic                          busy_o,
  output logic                          doneStrb_o
);
  localparam int CPB = clksPerBit(CLK_FREQ, BAUD_RATE);

  msgState_e                     state, nextState;
  logic [`MIDI_PAYLOAD_BITS-1:0] noteReg, velReg;
  logic                          accept, txStart, txBusy, txDone;
  logic [7:0]                    txByte;

  assign busy_o = (state != IDLE);

  // Byte mux: the status byte is built straight from the strobes in the
  // acceptance cycle so the start bit leaves on the very next cycle.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    txStart   = 1'b0;
    txByte    = 8'h00;
    case (state)
      IDLE: if ((noteOnStrb_i || noteOffStrb_i) && !txBusy) begin
        accept    = 1'b1;
        txStart   = 1'b1;
        txByte    = {noteOnStrb_i ? MIDI_NOTE_ON : MIDI_NOTE_OFF, 4'(MIDI_CHANNEL)};
        nextState = STATUS;
      end
      STATUS: if (txDone) begin
        txStart   = 1'b1;
        txByte    = noteReg;
        nextState = DATA1;
      end
      DATA1: if (txDone) begin
        txStart   = 1'b1;
        txByte    = velReg;
        nextState = DATA2;
      end
      DATA2: if (txDone) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state      <= IDLE;
      noteReg    <= '0;
      velReg     <= '0;
      doneStrb_o <= 1'b0;
    end else begin
      state      <= nextState;
      doneStrb_o <= (state == DATA2) && txDone;
      if (accept) begin
        // MSB cleared here so data bytes can never look like status bytes.
        noteReg <= note_i & 8'h7F;
        velReg  <= velocity_i & 8'h7F;
      end
    end
  end

  midi_tx_byte #(.CLKS_PER_BIT(CPB)) uByte (
    .clk_i    (clk_i),
    .nrst_i   (nrst_i),
    .start_i  (txStart),
    .data_i   (txByte),
    .txData_o (txData_o),
    .busy_o   (txBusy),
    .done_o   (txDone)
  );
endmodule
